newhope_xfer_ctrl: RTL and testbench

Parametrised byte-stream transfer engine that moves a contiguous block of bytes from a byte-wide source RAM into a word- or byte-wide destination RAM. Bytes are packed little-endian into destination words. It replaces the hand-sequenced copy loops that currently run between the key generator output RAM and the encrypter/decrypter input RAMs (pubseed, pk, sk, ciphertext). One transfer runs per start pulse: source reads are pipelined at one byte per cycle, and a descriptor is checked before the transfer begins.

---
 rtl/newhope_xfer_ctrl.sv | 149 ++++++++++++++
 tb/tb_newhope_xfer_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/newhope_xfer_ctrl.sv
`default_nettype none
// newhope_xfer_ctrl: copies a byte block from a byte-wide source RAM into a
// word-wide destination RAM, packing bytes little-endian. Revision: 1.0
module newhope_xfer_ctrl #(
   parameter int SRC_AW     = 11,
   parameter int DST_AW     = 10,
   parameter int LEN_W      = 11,
   parameter int WORD_BYTES = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [SRC_AW-1:0]       src_base_i,
   input  logic [DST_AW-1:0]       dst_base_i,
   input  logic [LEN_W-1:0]        len_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic [SRC_AW-1:0]       src_addr_o,
   input  logic [7:0]              src_data_i,
   output logic                    dst_we_o,
   output logic [DST_AW-1:0]       dst_addr_o,
   output logic [8*WORD_BYTES-1:0] dst_data_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_e;

   localparam int                LANE_W    = 2;
   localparam logic [LEN_W-1:0]  WB_LEN    = LEN_W'(WORD_BYTES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

   state_e                  state_q, state_d;
   logic [SRC_AW-1:0]       src_addr_q;
   logic [LEN_W-1:0]        issue_left_q;
   logic [LEN_W-1:0]        cap_left_q;
   logic [DST_AW-1:0]       waddr_nxt_q;
   logic [DST_AW-1:0]       dst_addr_q;
   logic [LANE_W-1:0]       lane_q;
   logic [8*WORD_BYTES-1:0] pack_q;
   logic [8*WORD_BYTES-1:0] dst_data_q;
   logic                    dst_we_q;
   logic                    err_q;

   logic                    desc_ok;
   logic                    can_start;
   logic                    accept;
   logic                    issue;
   logic                    last_issue;
   logic                    cap;
   logic [8*WORD_BYTES-1:0] pack_w;

   // FIN behaves as idle towards start so back-to-back transfers lose no cycle.
   always_comb begin
      desc_ok    = (len_i != '0) && ((len_i % WB_LEN) == '0);
      can_start  = (state_q == S_IDLE) || (state_q == S_FIN);
      accept     = start_i && can_start && desc_ok;
      issue      = (state_q == S_READ);
      last_issue = issue && (issue_left_q == LEN_W'(1));
      pack_w     = pack_q;
      pack_w[{lane_q, 3'b000} +: 8] = src_data_i;
      state_d    = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_READ;
         S_READ:  if (last_issue) state_d = S_DRAIN;
         S_DRAIN: if (dst_we_q && (cap_left_q == '0)) state_d = S_FIN;
         S_FIN:   state_d = accept ? S_READ : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   generate
      if (RD_LAT == 0) begin : g_lat0
         assign cap = issue;
      end else begin : g_latn
         logic [RD_LAT-1:0] vld_q;
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= issue;
               for (int j = 1; j < RD_LAT; j++) vld_q[j] <= vld_q[j-1];
            end
         end
         assign cap = vld_q[RD_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         src_addr_q   <= '0;
         issue_left_q <= '0;
         cap_left_q   <= '0;
         waddr_nxt_q  <= '0;
         dst_addr_q   <= '0;
         lane_q       <= '0;
         pack_q       <= '0;
         dst_data_q   <= '0;
         dst_we_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         err_q    <= start_i && can_start && !desc_ok;
         dst_we_q <= 1'b0;
         if (accept) begin
            src_addr_q   <= src_base_i;
            issue_left_q <= len_i;
            cap_left_q   <= len_i;
            waddr_nxt_q  <= dst_base_i;
            lane_q       <= '0;
         end else if (issue && !last_issue) begin
            src_addr_q   <= src_addr_q + SRC_AW'(1);
            issue_left_q <= issue_left_q - LEN_W'(1);
         end
         if (cap) begin
            pack_q     <= pack_w;
            cap_left_q <= cap_left_q - LEN_W'(1);
            if (lane_q == LAST_LANE) begin
               lane_q      <= '0;
               dst_we_q    <= 1'b1;
               dst_addr_q  <= waddr_nxt_q;
               dst_data_q  <= pack_w;
               waddr_nxt_q <= waddr_nxt_q + DST_AW'(1);
            end else begin
               lane_q <= lane_q + LANE_W'(1);
            end
         end
      end
   end

   assign busy_o     = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done_o     = (state_q == S_FIN);
   assign err_o      = err_q;
   assign src_addr_o = src_addr_q;
   assign dst_we_o   = dst_we_q;
   assign dst_addr_o = dst_addr_q;
   assign dst_data_o = dst_data_q;

endmodule
`default_nettype wire

// File: tb/tb_newhope_xfer_ctrl.sv
`default_nettype none
// tb_newhope_xfer_ctrl: five engine configurations driven in parallel, each
// checked every cycle against a timeline model of the transfer.
module tb_newhope_xfer_ctrl;

   localparam int          N    = 5;
   localparam logic [19:0] WBS  = {4'd2, 4'd1, 4'd1, 4'd1, 4'd4};
   localparam logic [19:0] LATS = {4'd0, 4'd2, 4'd1, 4'd0, 4'd1};

   logic        clk = 1'b0;
   logic        rst_n, start, chk_en;
   logic [10:0] src_base, len;
   logic [9:0]  dst_base;
   logic [7:0]  mem [0:2047];

   logic [N-1:0] busy_v, done_v, err_v, we_v;
   logic [10:0]  sa_v [N];
   logic [9:0]   da_v [N];
   logic [31:0]  dd_v [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] at %0t: got %0h, want %0h", nm, inst, $time, got, exp);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int WB = int'(WBS[g*4 +: 4]);
      localparam int RL = int'(LATS[g*4 +: 4]);

      logic [10:0]     sa;
      logic [7:0]      sd, p0, p1;
      logic [9:0]      da;
      logic [8*WB-1:0] dd;
      logic            busy, done, err, we;

      newhope_xfer_ctrl #(
         .SRC_AW(11), .DST_AW(10), .LEN_W(11), .WORD_BYTES(WB), .RD_LAT(RL)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n), .start_i(start),
         .src_base_i(src_base), .dst_base_i(dst_base), .len_i(len),
         .busy_o(busy), .done_o(done), .err_o(err),
         .src_addr_o(sa), .src_data_i(sd),
         .dst_we_o(we), .dst_addr_o(da), .dst_data_o(dd)
      );

      always @(posedge clk) begin
         p0 <= mem[sa];
         p1 <= p0;
      end
      assign sd = (RL == 0) ? mem[sa] : ((RL == 1) ? p0 : p1);

      assign busy_v[g] = busy;
      assign done_v[g] = done;
      assign err_v[g]  = err;
      assign we_v[g]   = we;
      assign sa_v[g]   = sa;
      assign da_v[g]   = da;
      assign dd_v[g]   = 32'(dd);

      // Model: c is the cycle number relative to the accepting edge.
      bit          act_q, xw_q, xe_q;
      int          c_q, ln_q;
      logic [10:0] sb_q, xs_q;
      logic [9:0]  db_q, xa_q;
      logic [31:0] xd_q;

      always @(posedge clk) begin : mdl
         bit          act, idle, xw, xe;
         int          c, ln, k, w;
         logic [10:0] sb, xs;
         logic [9:0]  db, xa;
         logic [31:0] xd;
         act = act_q; c = c_q; ln = ln_q; sb = sb_q; db = db_q;
         xs = xs_q; xa = xa_q; xd = xd_q; xw = 1'b0; xe = 1'b0;
         if (!rst_n) begin
            act = 1'b0; c = 0; xs = '0; xa = '0; xd = '0;
         end else begin
            idle = !act || (c == ln + RL + 2);
            if (act) c++;
            if (act && c > ln + RL + 2) act = 1'b0;
            if (start && idle) begin
               if (len != 0 && (int'(len) % WB) == 0) begin
                  act = 1'b1; c = 1; ln = int'(len); sb = src_base; db = dst_base;
               end else begin
                  xe = 1'b1;
               end
            end
            if (act) begin
               if (c <= ln) xs = sb + 11'(c - 1);
               k = c - RL - 1;
               if (k >= WB && (k % WB) == 0 && (k / WB) <= (ln / WB)) begin
                  w  = k / WB - 1;
                  xw = 1'b1;
                  xa = db + 10'(w);
                  xd = '0;
                  for (int j = 0; j < WB; j++) xd[8*j +: 8] = mem[sb + 11'(w*WB + j)];
               end
            end
         end
         act_q <= act; c_q <= c; ln_q <= ln; sb_q <= sb; db_q <= db;
         xs_q <= xs; xa_q <= xa; xd_q <= xd; xw_q <= xw; xe_q <= xe;
      end

      always @(negedge clk) begin
         if (chk_en) begin
            chk("busy",     g, 32'(busy), 32'(act_q && c_q <= ln_q + RL + 1));
            chk("done",     g, 32'(done), 32'(act_q && c_q == ln_q + RL + 2));
            chk("err",      g, 32'(err),  32'(xe_q));
            chk("dst_we",   g, 32'(we),   32'(xw_q));
            chk("src_addr", g, 32'(sa),   32'(xs_q));
            chk("dst_addr", g, 32'(da),   32'(xa_q));
            chk("dst_data", g, 32'(dd),   xd_q);
         end
      end
   end

   int          done_at [N];
   int          err_at  [N];
   int          we_cnt  [N];
   int          busy_cnt[N];
   logic [9:0]  wa0[$];
   logic [31:0] wd0[$];
   logic [10:0] sa0[$];

   task automatic go(input logic [10:0] sb, input logic [9:0] db, input logic [10:0] ln);
      @(negedge clk);
      src_base = sb; dst_base = db; len = ln; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Records outputs from cycle n0 (current negedge) to cycle n1.
   task automatic observe(input int n0, input int n1);
      for (int i = 0; i < N; i++) begin
         done_at[i] = -1; err_at[i] = -1; we_cnt[i] = 0; busy_cnt[i] = 0;
      end
      wa0.delete(); wd0.delete(); sa0.delete();
      for (int n = n0; n <= n1; n++) begin
         for (int i = 0; i < N; i++) begin
            if (done_v[i] && done_at[i] < 0) done_at[i] = n;
            if (err_v[i] && err_at[i] < 0) err_at[i] = n;
            if (we_v[i]) we_cnt[i]++;
            if (busy_v[i]) busy_cnt[i]++;
         end
         if (we_v[0]) begin
            wa0.push_back(da_v[0]);
            wd0.push_back(dd_v[0]);
         end
         sa0.push_back(sa_v[0]);
         if (n < n1) @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; len = '0; chk_en = 1'b0;
      for (int a = 0; a < 2048; a++) mem[a] = 8'(a);
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      chk("rst_busy", 0, 32'(busy_v), 32'd0);
      chk("rst_done", 0, 32'(done_v), 32'd0);
      chk("rst_err",  0, 32'(err_v),  32'd0);
      chk("rst_we",   0, 32'(we_v),   32'd0);
      chk("rst_sa",   0, 32'(sa_v[0]), 32'd0);
      chk("rst_da",   0, 32'(da_v[0]), 32'd0);
      chk("rst_dd",   0, dd_v[0],      32'd0);

      // Pubseed load
      go(11'd1792, 10'd8, 11'd32);
      observe(1, 40);
      chk("pub_done", 0, done_at[0], 35);
      chk("pub_done", 1, done_at[1], 34);
      chk("pub_done", 3, done_at[3], 36);
      chk("pub_nwr",  0, we_cnt[0], 8);
      chk("pub_nwr",  1, we_cnt[1], 32);
      chk("pub_nwr",  4, we_cnt[4], 16);
      chk("pub_wsz",  0, wa0.size(), 8);
      if (wa0.size() == 8) begin
         chk("pub_a0", 0, 32'(wa0[0]), 32'd8);
         chk("pub_d0", 0, wd0[0], 32'h0302_0100);
         chk("pub_a7", 0, 32'(wa0[7]), 32'd15);
         chk("pub_d7", 0, wd0[7], 32'h1F1E_1D1C);
      end

      // Byte copy across all latencies
      go(11'd896, 10'd0, 11'd896);
      observe(1, 905);
      chk("cpy_done", 0, done_at[0], 899);
      chk("cpy_done", 1, done_at[1], 898);
      chk("cpy_done", 2, done_at[2], 899);
      chk("cpy_done", 3, done_at[3], 900);
      chk("cpy_done", 4, done_at[4], 898);
      chk("cpy_nwr",  2, we_cnt[2], 896);
      chk("cpy_nwr",  0, we_cnt[0], 224);
      chk("cpy_d0",   0, (wd0.size() > 0) ? wd0[0] : 32'hDEAD_BEEF, 32'h8382_8180);

      // Rejects: len=6 is illegal only for 4-byte words; len=0 everywhere
      go(11'd0, 10'd0, 11'd6);
      observe(1, 12);
      chk("rej6_err",  0, err_at[0], 1);
      chk("rej6_busy", 0, busy_cnt[0], 0);
      chk("rej6_we",   0, we_cnt[0], 0);
      chk("rej6_sa0",  0, 32'(sa0[0]), 32'd1791);
      chk("rej6_sa11", 0, 32'(sa0[11]), 32'd1791);
      chk("rej6_err",  1, err_at[1], -1);
      chk("rej6_done", 3, done_at[3], 10);
      chk("rej6_done", 4, done_at[4], 8);
      go(11'd5, 10'd5, 11'd0);
      observe(1, 6);
      for (int i = 0; i < N; i++) begin
         chk("rej0_err",  i, err_at[i], 1);
         chk("rej0_busy", i, busy_cnt[i], 0);
         chk("rej0_we",   i, we_cnt[i], 0);
      end

      // Address wrap on both sides
      go(11'd2040, 10'd1022, 11'd16);
      observe(1, 22);
      chk("wrap_done", 0, done_at[0], 19);
      chk("wrap_sa1",  0, 32'(sa0[0]),  32'd2040);
      chk("wrap_sa8",  0, 32'(sa0[7]),  32'd2047);
      chk("wrap_sa9",  0, 32'(sa0[8]),  32'd0);
      chk("wrap_sa16", 0, 32'(sa0[15]), 32'd7);
      chk("wrap_wsz",  0, wa0.size(), 4);
      if (wa0.size() == 4) begin
         chk("wrap_a0", 0, 32'(wa0[0]), 32'd1022);
         chk("wrap_a1", 0, 32'(wa0[1]), 32'd1023);
         chk("wrap_a2", 0, 32'(wa0[2]), 32'd0);
         chk("wrap_a3", 0, 32'(wa0[3]), 32'd1);
         chk("wrap_d0", 0, wd0[0], 32'hFBFA_F9F8);
         chk("wrap_d2", 0, wd0[2], 32'h0302_0100);
      end

      // start while busy is ignored
      go(11'd100, 10'd20, 11'd64);
      repeat (4) @(negedge clk);
      src_base = 11'd500; dst_base = 10'd300; len = 11'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      observe(6, 75);
      chk("bsy_done", 0, done_at[0], 67);
      chk("bsy_done", 3, done_at[3], 68);
      chk("bsy_err",  0, err_at[0], -1);
      chk("bsy_nwr",  0, we_cnt[0], 16);
      chk("bsy_a15",  0, (wa0.size() == 16) ? 32'(wa0[15]) : 32'hDEAD_BEEF, 32'd35);

      // Reset in the middle of a transfer
      go(11'd300, 10'd40, 11'd64);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstm_busy", 0, 32'(busy_v), 32'd0);
      observe(11, 60);
      for (int i = 0; i < N; i++) begin
         chk("rstm_done", i, done_at[i], -1);
         chk("rstm_we",   i, we_cnt[i], 0);
      end
      go(11'd1792, 10'd8, 11'd32);
      observe(1, 40);
      chk("post_done", 0, done_at[0], 35);
      chk("post_nwr",  0, we_cnt[0], 8);
      chk("post_d0",   0, (wd0.size() > 0) ? wd0[0] : 32'hDEAD_BEEF, 32'h0302_0100);

      // New start in the done cycle is accepted
      go(11'd0, 10'd100, 11'd8);
      repeat (9) @(negedge clk);
      go(11'd8, 10'd200, 11'd8);
      observe(1, 20);
      chk("b2b_done", 0, done_at[0], 11);
      chk("b2b_a0",   0, (wa0.size() > 0) ? 32'(wa0[0]) : 32'hDEAD_BEEF, 32'd200);
      chk("b2b_d1",   0, (wd0.size() > 1) ? wd0[1] : 32'hDEAD_BEEF, 32'h0F0E_0D0C);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
